triumph_id_stage: RTL and testbench

TRIUMPH_ID_STAGE -- requirements
Module: triumph_id_stage

---
 rtl/triumph_pkg.sv | 50 +++++
 rtl/triumph_decoder.sv | 55 +++++
 rtl/triumph_id_stage.sv | 124 ++++++++++++
 tb/tb_triumph_id_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/triumph_pkg.sv
// Shared opcode, ALU-op and FSM-state definitions for the triumph ID stage.
package triumph_pkg;

  localparam logic [5:0] OpNop  = 6'h00;
  localparam logic [5:0] OpAdd  = 6'h01;
  localparam logic [5:0] OpSub  = 6'h02;
  localparam logic [5:0] OpAnd  = 6'h03;
  localparam logic [5:0] OpOr   = 6'h04;
  localparam logic [5:0] OpXor  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h10;
  localparam logic [5:0] OpSw   = 6'h11;
  localparam logic [5:0] OpBeq  = 6'h20;
  localparam logic [5:0] OpBne  = 6'h21;

  typedef enum logic [3:0] {
    AluAdd  = 4'h0,
    AluSub  = 4'h1,
    AluAnd  = 4'h2,
    AluOr   = 4'h3,
    AluXor  = 4'h4,
    AluPass = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StSquash = 2'd2
  } id_state_e;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        we;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        bne;
    logic        illegal;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/triumph_decoder.sv
// Combinational instruction decoder: splits the word into register fields,
// sign-extended immediate and control flags.
module triumph_decoder
  import triumph_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm,
  output logic [3:0]  o_alu_op,
  output logic        o_we,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_branch,
  output logic        o_bne,
  output logic        o_illegal
);

  logic [5:0] w_opcode;
  logic       w_writes;

  assign w_opcode = i_instr[31:26];
  assign o_rd     = i_instr[25:21];
  assign o_rs1    = i_instr[20:16];
  assign o_rs2    = i_instr[15:11];
  assign o_imm    = sext16(i_instr[15:0]);

  always_comb begin
    o_alu_op  = AluPass;
    w_writes  = 1'b0;
    o_mem_rd  = 1'b0;
    o_mem_wr  = 1'b0;
    o_branch  = 1'b0;
    o_bne     = 1'b0;
    o_illegal = 1'b0;
    unique case (w_opcode)
      OpNop:  ;
      OpAdd:  begin o_alu_op = AluAdd; w_writes = 1'b1; end
      OpSub:  begin o_alu_op = AluSub; w_writes = 1'b1; end
      OpAnd:  begin o_alu_op = AluAnd; w_writes = 1'b1; end
      OpOr:   begin o_alu_op = AluOr;  w_writes = 1'b1; end
      OpXor:  begin o_alu_op = AluXor; w_writes = 1'b1; end
      OpAddi: begin o_alu_op = AluAdd; w_writes = 1'b1; end
      OpLw:   begin o_alu_op = AluAdd; w_writes = 1'b1; o_mem_rd = 1'b1; end
      OpSw:   begin o_alu_op = AluAdd; o_mem_wr = 1'b1; end
      // Branches compare by subtraction in EX.
      OpBeq:  begin o_alu_op = AluSub; o_branch = 1'b1; end
      OpBne:  begin o_alu_op = AluSub; o_branch = 1'b1; o_bne = 1'b1; end
      default: o_illegal = 1'b1;
    endcase
    o_we = w_writes & (o_rd != 5'd0);
  end

endmodule

// File: rtl/triumph_id_stage.sv
// Decode stage: load-use hazard stall, flush squash, EX backpressure and the
// ID/EX pipeline register. Invalid entries always carry all-zero fields.
module triumph_id_stage
  import triumph_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_data_i,
  output logic        id_ready_o,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_i,
  output logic        id_valid_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] imm_o,
  output logic [3:0]  alu_op_o,
  output logic        we_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        branch_o,
  output logic        bne_o,
  output logic        illegal_o,
  output logic [31:0] opPC_data_o
);

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm;
  logic [3:0]  w_alu_op;
  logic        w_we, w_mem_rd, w_mem_wr, w_branch, w_bne, w_illegal;
  id_ex_t      w_dec;
  logic        w_hazard;
  logic        w_hold;

  id_state_e   r_state;
  logic        r_valid;
  id_ex_t      r_ex;

  triumph_decoder u_decoder (
    .i_instr   (instr_data_i),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_imm     (w_imm),
    .o_alu_op  (w_alu_op),
    .o_we      (w_we),
    .o_mem_rd  (w_mem_rd),
    .o_mem_wr  (w_mem_wr),
    .o_branch  (w_branch),
    .o_bne     (w_bne),
    .o_illegal (w_illegal)
  );

  assign w_dec = '{rs1: w_rs1, rs2: w_rs2, rd: w_rd, imm: w_imm, alu_op: w_alu_op,
                   we: w_we, mem_rd: w_mem_rd, mem_wr: w_mem_wr, branch: w_branch,
                   bne: w_bne, illegal: w_illegal};

  assign w_hazard = ex_load_i & (ex_rd_i != 5'd0) &
                    ((ex_rd_i == w_rs1) | (ex_rd_i == w_rs2)) & instr_valid_i;
  assign w_hold   = r_valid & ~ex_ready_i;

  assign id_ready_o = ~rst_i & (((r_state == StRun) & ~w_hazard & (~r_valid | ex_ready_i)) |
                                (r_state == StSquash));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StRun;
      r_valid <= 1'b0;
      r_ex    <= '0;
    end else if (flush_i) begin
      r_state <= StSquash;
      r_valid <= 1'b0;
      r_ex    <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_hazard) begin
            r_state <= StStall;
          end
          // A stalled EX keeps the current entry even while a hazard is noted.
          if (!w_hold) begin
            if (!w_hazard && instr_valid_i) begin
              r_valid <= 1'b1;
              r_ex    <= w_dec;
            end else begin
              r_valid <= 1'b0;
              r_ex    <= '0;
            end
          end
        end
        StStall, StSquash: begin
          r_state <= StRun;
          if (!w_hold) begin
            r_valid <= 1'b0;
            r_ex    <= '0;
          end
        end
        default: begin
          r_state <= StRun;
          r_valid <= 1'b0;
          r_ex    <= '0;
        end
      endcase
    end
  end

  assign id_valid_o  = r_valid;
  assign rs1_addr_o  = r_ex.rs1;
  assign rs2_addr_o  = r_ex.rs2;
  assign rd_addr_o   = r_ex.rd;
  assign imm_o       = r_ex.imm;
  assign alu_op_o    = r_ex.alu_op;
  assign we_o        = r_ex.we;
  assign mem_rd_o    = r_ex.mem_rd;
  assign mem_wr_o    = r_ex.mem_wr;
  assign branch_o    = r_ex.branch;
  assign bne_o       = r_ex.bne;
  assign illegal_o   = r_ex.illegal;
  assign opPC_data_o = r_ex.branch ? r_ex.imm : 32'd0;

endmodule

// File: tb/tb_triumph_id_stage.sv
// Self-checking bench for triumph_id_stage: cycle-level reference model plus
// literal expectations on hand-built instruction words.
module tb_triumph_id_stage;

  logic        clk = 1'b0;
  logic        rst_i, instr_valid_i, flush_i, ex_ready_i, ex_load_i;
  logic [31:0] instr_data_i;
  logic [4:0]  ex_rd_i;
  logic        id_ready_o, id_valid_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] imm_o, opPC_data_o;
  logic [3:0]  alu_op_o;
  logic        we_o, mem_rd_o, mem_wr_o, branch_o, bne_o, illegal_o;
  logic [56:0] dut_regs;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_known  = 1'b0;
  bit          m_valid  = 1'b0;
  bit          m_stall  = 1'b0;
  bit          m_squash = 1'b0;
  logic [56:0] m_regs   = '0;

  always #5 clk = ~clk;

  triumph_id_stage dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_data_i  (instr_data_i),
    .id_ready_o    (id_ready_o),
    .flush_i       (flush_i),
    .ex_ready_i    (ex_ready_i),
    .ex_load_i     (ex_load_i),
    .ex_rd_i       (ex_rd_i),
    .id_valid_o    (id_valid_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rd_addr_o     (rd_addr_o),
    .imm_o         (imm_o),
    .alu_op_o      (alu_op_o),
    .we_o          (we_o),
    .mem_rd_o      (mem_rd_o),
    .mem_wr_o      (mem_wr_o),
    .branch_o      (branch_o),
    .bne_o         (bne_o),
    .illegal_o     (illegal_o),
    .opPC_data_o   (opPC_data_o)
  );

  // Layout: rs1 rs2 rd imm alu we mem_rd mem_wr branch bne illegal (MSB..LSB).
  assign dut_regs = {rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, alu_op_o,
                     we_o, mem_rd_o, mem_wr_o, branch_o, bne_o, illegal_o};

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // Expected ID/EX contents for an instruction word, from the opcode table.
  function automatic logic [56:0] model_decode(input logic [31:0] w);
    logic [3:0] alu;
    logic       we, mr, mw, br, bn, il;
    alu = 4'hF; we = 0; mr = 0; mw = 0; br = 0; bn = 0; il = 0;
    case (w[31:26])
      6'h00: ;
      6'h01: begin alu = 4'h0; we = 1; end
      6'h02: begin alu = 4'h1; we = 1; end
      6'h03: begin alu = 4'h2; we = 1; end
      6'h04: begin alu = 4'h3; we = 1; end
      6'h05: begin alu = 4'h4; we = 1; end
      6'h08: begin alu = 4'h0; we = 1; end
      6'h10: begin alu = 4'h0; we = 1; mr = 1; end
      6'h11: begin alu = 4'h0; mw = 1; end
      6'h20: begin alu = 4'h1; br = 1; end
      6'h21: begin alu = 4'h1; br = 1; bn = 1; end
      default: il = 1;
    endcase
    if (w[25:21] == 5'd0) we = 0;
    return {w[20:16], w[15:11], w[25:21], {{16{w[15]}}, w[15:0]}, alu, we, mr, mw, br, bn, il};
  endfunction

  function automatic bit model_hazard();
    return ex_load_i && ex_rd_i != 0 && instr_valid_i &&
           (ex_rd_i == instr_data_i[20:16] || ex_rd_i == instr_data_i[15:11]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit rdy;
    if (!m_known) return;
    rdy = !rst_i && ((!m_stall && !m_squash && !model_hazard() && (!m_valid || ex_ready_i))
                     || m_squash);
    chk("id_ready", 64'(id_ready_o), 64'(rdy));
    chk("id_valid", 64'(id_valid_o), 64'(m_valid));
    chk("id_ex_regs", 64'(dut_regs), 64'(m_regs));
    chk("opPC", 64'(opPC_data_o), m_regs[2] ? 64'(m_regs[41:10]) : 64'd0);
  endtask

  task automatic model_step();
    bit hz, hold;
    hz   = model_hazard();
    hold = m_valid && !ex_ready_i;
    if (rst_i) begin
      m_known = 1; m_valid = 0; m_regs = '0; m_stall = 0; m_squash = 0;
    end else if (flush_i) begin
      m_valid = 0; m_regs = '0; m_stall = 0; m_squash = 1;
    end else if (m_stall || m_squash) begin
      m_stall = 0; m_squash = 0;
      if (!hold) begin m_valid = 0; m_regs = '0; end
    end else begin
      if (hz) m_stall = 1;
      if (!hold) begin
        if (!hz && instr_valid_i) begin m_valid = 1; m_regs = model_decode(instr_data_i); end
        else begin m_valid = 0; m_regs = '0; end
      end
    end
  endtask

  // One clock: drive, compare at negedge, advance model at posedge, settle.
  task automatic tick(input bit rst, input bit iv, input logic [31:0] instr, input bit fl,
                      input bit er, input bit el, input logic [4:0] erd);
    rst_i = rst; instr_valid_i = iv; instr_data_i = instr; flush_i = fl;
    ex_ready_i = er; ex_load_i = el; ex_rd_i = erd;
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [31:0] i_add, i_haz;

  initial begin
    i_add = 32'h0461_1000;                          // ADD r3,r1,r2
    i_haz = enc(6'h01, 5'd4, 5'd5, {5'd6, 11'd0});  // ADD r4,r5,r6

    tick(1, 0, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 1, 0, 0);
    chk("rst_valid", 64'(id_valid_o), 0);
    chk("rst_regs", 64'(dut_regs), 0);
    chk("rst_opPC", 64'(opPC_data_o), 0);
    chk("rst_ready", 64'(id_ready_o), 0);

    tick(0, 1, i_add, 0, 1, 0, 0);
    chk("add_valid", 64'(id_valid_o), 1);
    chk("add_rd", 64'(rd_addr_o), 3);
    chk("add_rs1", 64'(rs1_addr_o), 1);
    chk("add_rs2", 64'(rs2_addr_o), 2);
    chk("add_alu", 64'(alu_op_o), 0);
    chk("add_we", 64'(we_o), 1);

    tick(0, 1, enc(6'h20, 5'd0, 5'd1, 16'hFFFC), 0, 1, 0, 0);
    chk("beq_imm", 64'(imm_o), 64'hFFFF_FFFC);
    chk("beq_opPC", 64'(opPC_data_o), 64'hFFFF_FFFC);
    chk("beq_branch", 64'(branch_o), 1);
    chk("beq_we", 64'(we_o), 0);

    // Load-use hazard on rs1.
    tick(0, 1, i_haz, 0, 1, 1, 5'd5);
    chk("haz_bubble", 64'(id_valid_o), 0);
    chk("haz_ready", 64'(id_ready_o), 0);
    tick(0, 1, i_haz, 0, 1, 0, 0);
    tick(0, 1, i_haz, 0, 1, 0, 0);
    chk("haz_capture", 64'(id_valid_o), 1);
    chk("haz_rd", 64'(rd_addr_o), 4);

    // Backpressure for three cycles, then an illegal opcode.
    tick(0, 1, enc(6'h02, 5'd7, 5'd1, 16'h1000), 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, enc(6'h05, 5'd8, 5'd2, 16'h0800), 0, 0, 0, 0);
      chk("bp_rd", 64'(rd_addr_o), 7);
      chk("bp_ready", 64'(id_ready_o), 0);
    end
    tick(0, 1, enc(6'h3F, 5'd12, 5'd1, 16'h0000), 0, 1, 0, 0);
    chk("ill_flag", 64'(illegal_o), 1);
    chk("ill_we", 64'(we_o), 0);

    // Flush with a valid entry in ID; the next instruction is discarded.
    tick(0, 1, enc(6'h10, 5'd9, 5'd1, 16'h0004), 0, 1, 0, 0);
    tick(0, 1, enc(6'h04, 5'd10, 5'd1, 16'h0000), 1, 1, 0, 0);
    chk("flush_valid", 64'(id_valid_o), 0);
    tick(0, 1, enc(6'h03, 5'd11, 5'd1, 16'h0000), 0, 1, 0, 0);
    chk("squash_discard", 64'(id_valid_o), 0);
    tick(0, 1, enc(6'h03, 5'd11, 5'd1, 16'h0000), 0, 1, 0, 0);
    chk("post_squash_rd", 64'(rd_addr_o), 11);

    // Flush together with hazard: squash, not stall.
    tick(0, 1, i_haz, 1, 1, 1, 5'd5);
    chk("flushhaz_ready", 64'(id_ready_o), 1);
    tick(0, 0, 0, 0, 1, 0, 0);

    // Reset during stall.
    tick(0, 1, i_haz, 0, 1, 1, 5'd5);
    tick(1, 1, i_add, 0, 1, 0, 0);
    chk("rststall_valid", 64'(id_valid_o), 0);
    chk("rststall_regs", 64'(dut_regs), 0);
    tick(0, 1, i_add, 0, 1, 0, 0);
    chk("rststall_run", 64'(id_valid_o), 1);

    // Flush during stall.
    tick(0, 1, i_haz, 0, 1, 1, 5'd6);
    tick(0, 1, i_haz, 1, 1, 0, 0);
    chk("flushstall_ready", 64'(id_ready_o), 1);

    // ADDI rd=0, SW, BNE, NOP.
    tick(0, 1, enc(6'h08, 5'd0, 5'd1, 16'h8000), 0, 1, 0, 0);
    tick(0, 1, enc(6'h08, 5'd0, 5'd1, 16'h8000), 0, 1, 0, 0);
    chk("addi_imm", 64'(imm_o), 64'hFFFF_8000);
    chk("addi_we", 64'(we_o), 0);
    tick(0, 1, enc(6'h11, 5'd2, 5'd3, 16'h0010), 0, 1, 0, 0);
    chk("sw_memwr", 64'(mem_wr_o), 1);
    tick(0, 1, enc(6'h21, 5'd0, 5'd1, 16'h0004), 0, 1, 0, 0);
    chk("bne_flag", 64'(bne_o), 1);
    chk("bne_opPC", 64'(opPC_data_o), 4);
    tick(0, 1, 32'h0000_0000, 0, 1, 0, 0);
    chk("nop_alu", 64'(alu_op_o), 64'hF);

    // Mixed traffic checked against the model only.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] ops [12];
      logic [5:0] op;
      ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h10, 6'h11, 6'h20,
              6'h21, 6'h2A};
      op = ops[$urandom_range(0, 11)];
      tick(0, 1'($urandom_range(0, 3) != 0),
           enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
